// File: rtl/grn_ctrl_pkg.sv
// Shared types and constants for the GRN attractor controller.
//   state_e    : controller FSM states
//   CNT_W_DEF  : default width of the step/period counters
//   STROBE_LAT : cycles from a registered strobe to the node update becoming visible
package grn_ctrl_pkg;

   typedef enum logic [3:0] {
      StIdle,
      StLoad,
      StSettle,
      StStep,
      StCheck,
      StPstep,
      StPcheck,
      StDone,
      StTimeout
   } state_e;

   localparam int unsigned CNT_W_DEF  = 16;
   localparam int unsigned STROBE_LAT = 1;

endpackage

// File: rtl/grn_attractor_ctrl_if.sv
// Bundle between the attractor controller, its host and the GRN node array.
// Host side:  go, init_vec (to ctrl); busy, done, timeout, meet_steps, period (from ctrl)
// Node side:  s0_vec, s1_vec (to ctrl); init_state, reset_nos, start_s0, start_s1 (from ctrl)
// Optional (ATTRACTOR_SNAP_EN): snap_vec, a state captured on the attractor.
// slave  : the controller's view
// master : the host/node-array view
interface grn_attractor_ctrl_if
   import grn_ctrl_pkg::*;
#(
   parameter int unsigned N_NODES = 38,
   parameter int unsigned CNT_W   = CNT_W_DEF
);

   logic               go;
   logic [N_NODES-1:0] init_vec;
   logic [N_NODES-1:0] s0_vec;
   logic [N_NODES-1:0] s1_vec;
   logic [N_NODES-1:0] init_state;
   logic               reset_nos;
   logic               start_s0;
   logic               start_s1;
   logic               busy;
   logic               done;
   logic               timeout;
   logic [CNT_W-1:0]   meet_steps;
   logic [CNT_W-1:0]   period;
`ifdef ATTRACTOR_SNAP_EN
   logic [N_NODES-1:0] snap_vec;
`endif

   modport slave (
      input  go,
      input  init_vec,
      input  s0_vec,
      input  s1_vec,
      output init_state,
      output reset_nos,
      output start_s0,
      output start_s1,
      output busy,
      output done,
      output timeout,
      output meet_steps,
      output period
`ifdef ATTRACTOR_SNAP_EN
      , output snap_vec
`endif
   );

   modport master (
      output go,
      output init_vec,
      output s0_vec,
      output s1_vec,
      input  init_state,
      input  reset_nos,
      input  start_s0,
      input  start_s1,
      input  busy,
      input  done,
      input  timeout,
      input  meet_steps,
      input  period
`ifdef ATTRACTOR_SNAP_EN
      , input snap_vec
`endif
   );

endinterface

// File: rtl/grn_vec_cmp.sv
// Purely combinational N_NODES-wide equality compare of two network states.
//   a, b : state vectors
//   eq   : high when a == b
module grn_vec_cmp
   import grn_ctrl_pkg::*;
#(
   parameter int unsigned N_NODES = 38
) (
   input  logic [N_NODES-1:0] a,
   input  logic [N_NODES-1:0] b,
   output logic               eq
);

   assign eq = (a == b);

endmodule

// File: rtl/grn_attractor_ctrl.sv
// Drives the GRN node array through Floyd cycle detection (tortoise s0, hare s1),
// then measures the attractor period by stepping only the hare.
// Ports: clk, rst (sync, active-high); bus (grn_attractor_ctrl_if.slave) carrying
//   go/init_vec in, busy/done/timeout/meet_steps/period out, node strobes and
//   init_state out, s0_vec/s1_vec in.
// Optional: define ATTRACTOR_SNAP_EN to add bus.snap_vec (s0 state captured at meet).
module grn_attractor_ctrl
   import grn_ctrl_pkg::*;
#(
   parameter int unsigned N_NODES   = 38,
   parameter int unsigned CNT_W     = CNT_W_DEF,
   parameter int unsigned MAX_STEPS = 1000
) (
   input logic                 clk,
   input logic                 rst,
   grn_attractor_ctrl_if.slave bus
);

   localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_STEPS);
   localparam logic [CNT_W-1:0] SatCnt = '1;

   state_e             state_q, state_d;
   logic [N_NODES-1:0] init_q, init_d;
   logic [CNT_W-1:0]   k_q, k_d;
   logic [CNT_W-1:0]   p_q, p_d;
   logic [CNT_W-1:0]   meet_q, meet_d;
   logic [CNT_W-1:0]   period_q, period_d;
   logic               done_q, done_d;
   logic               tmo_q, tmo_d;
   logic               reset_nos_q, reset_nos_d;
   logic               start_s0_q, start_s0_d;
   logic               start_s1_q, start_s1_d;
   logic               busy_q, busy_d;
   logic               vec_eq;
`ifdef ATTRACTOR_SNAP_EN
   logic [N_NODES-1:0] snap_q, snap_d;
`endif

   // One comparator shared by the Floyd check and the period check.
   grn_vec_cmp #(
      .N_NODES (N_NODES)
   ) u_cmp (
      .a  (bus.s0_vec),
      .b  (bus.s1_vec),
      .eq (vec_eq)
   );

   always_comb begin
      state_d  = state_q;
      init_d   = init_q;
      k_d      = k_q;
      p_d      = p_q;
      meet_d   = meet_q;
      period_d = period_q;
      done_d   = done_q;
      tmo_d    = tmo_q;
`ifdef ATTRACTOR_SNAP_EN
      snap_d   = snap_q;
`endif

      case (state_q)
         StIdle, StDone, StTimeout: begin
            if (bus.go) begin
               state_d  = StLoad;
               init_d   = bus.init_vec;
               k_d      = '0;
               p_d      = '0;
               meet_d   = '0;
               period_d = '0;
               done_d   = 1'b0;
               tmo_d    = 1'b0;
`ifdef ATTRACTOR_SNAP_EN
               snap_d   = '0;
`endif
            end
         end
         StLoad:   state_d = StSettle;
         StSettle: state_d = StStep;
         StStep: begin
            k_d     = (k_q == SatCnt) ? k_q : k_q + 1'b1;
            state_d = StCheck;
         end
         StCheck: begin
            // Odd k leaves the tortoise at x[ceil(k/2)], not x[k/2]; skip those compares.
            if (!k_q[0] && vec_eq) begin
               meet_d  = k_q;
               state_d = StPstep;
`ifdef ATTRACTOR_SNAP_EN
               snap_d  = bus.s0_vec;
`endif
            end else if (k_q == MaxCnt) begin
               tmo_d   = 1'b1;
               state_d = StTimeout;
            end else begin
               state_d = StStep;
            end
         end
         StPstep: begin
            p_d     = (p_q == SatCnt) ? p_q : p_q + 1'b1;
            state_d = StPcheck;
         end
         StPcheck: begin
            if (vec_eq) begin
               period_d = p_q;
               done_d   = 1'b1;
               state_d  = StDone;
            end else if (p_q == MaxCnt) begin
               tmo_d   = 1'b1;
               state_d = StTimeout;
            end else begin
               state_d = StPstep;
            end
         end
         default: state_d = StIdle;
      endcase

      // Strobes are registered from the next state so they are high during
      // the named state and the nodes update on the edge that leaves it.
      reset_nos_d = (state_d == StLoad);
      start_s0_d  = (state_d == StStep);
      start_s1_d  = (state_d == StStep) || (state_d == StPstep);
      busy_d      = !(state_d inside {StIdle, StDone, StTimeout});
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         init_q      <= '0;
         k_q         <= '0;
         p_q         <= '0;
         meet_q      <= '0;
         period_q    <= '0;
         done_q      <= 1'b0;
         tmo_q       <= 1'b0;
         reset_nos_q <= 1'b0;
         start_s0_q  <= 1'b0;
         start_s1_q  <= 1'b0;
         busy_q      <= 1'b0;
`ifdef ATTRACTOR_SNAP_EN
         snap_q      <= '0;
`endif
      end else begin
         state_q     <= state_d;
         init_q      <= init_d;
         k_q         <= k_d;
         p_q         <= p_d;
         meet_q      <= meet_d;
         period_q    <= period_d;
         done_q      <= done_d;
         tmo_q       <= tmo_d;
         reset_nos_q <= reset_nos_d;
         start_s0_q  <= start_s0_d;
         start_s1_q  <= start_s1_d;
         busy_q      <= busy_d;
`ifdef ATTRACTOR_SNAP_EN
         snap_q      <= snap_d;
`endif
      end
   end

   assign bus.init_state = init_q;
   assign bus.reset_nos  = reset_nos_q;
   assign bus.start_s0   = start_s0_q;
   assign bus.start_s1   = start_s1_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.timeout    = tmo_q;
   assign bus.meet_steps = meet_q;
   assign bus.period     = period_q;
`ifdef ATTRACTOR_SNAP_EN
   assign bus.snap_vec   = snap_q;
`endif

endmodule

// File: tb/tb_grn_attractor_ctrl.sv
// Bench for grn_attractor_ctrl: a 4-node network is modelled as a lookup
// table next-state function; a reference model computes the Floyd meet step,
// period and busy length from the state sequence, and a monitor compares
// every finished (or aborted) run against the queued expectation.
module tb_grn_attractor_ctrl;
   import grn_ctrl_pkg::*;

   localparam int unsigned NN   = 4;
   localparam int unsigned CW   = 16;
   localparam int unsigned MAXS = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   grn_attractor_ctrl_if #(.N_NODES(NN), .CNT_W(CW)) bus ();

   grn_attractor_ctrl #(
      .N_NODES   (NN),
      .CNT_W     (CW),
      .MAX_STEPS (MAXS)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Node array: s0 advances on every second start_s0 (first one included),
   // s1 on every start_s1; reset_nos loads init_state.
   logic [3:0]  f_tab [16];
   logic [3:0]  s0_q = '0;
   logic [3:0]  s1_q = '0;
   int unsigned s0_strobes = 0;

   always @(posedge clk) begin
      if (bus.reset_nos) begin
         s0_q       <= bus.init_state;
         s1_q       <= bus.init_state;
         s0_strobes <= 0;
      end else begin
         if (bus.start_s0) begin
            s0_strobes <= s0_strobes + 1;
            if (s0_strobes % 2 == 0) s0_q <= f_tab[s0_q];
         end
         if (bus.start_s1) s1_q <= f_tab[s1_q];
      end
   end

   assign bus.s0_vec = s0_q;
   assign bus.s1_vec = s1_q;

   typedef struct {
      bit          aborted;
      bit          done;
      bit          tmo;
      int unsigned meet;
      int unsigned period;
      int unsigned busy_cyc;
      logic [3:0]  snap;
   } exp_t;

   exp_t        exp_q[$];
   int unsigned checks       = 0;
   int unsigned errors       = 0;
   int unsigned idle_strobes = 0;
   int unsigned overlap      = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   // Reference: walk the orbit x[n] of the lookup-table network.
   function automatic exp_t model(input logic [3:0] init);
      logic [3:0]  xs [64];
      exp_t        e;
      int unsigned k;
      k          = 0;
      e.aborted  = 0;
      e.done     = 0;
      e.tmo      = 0;
      e.meet     = 0;
      e.period   = 0;
      e.busy_cyc = 0;
      e.snap     = '0;
      xs[0] = init;
      for (int i = 1; i < 64; i++) xs[i] = f_tab[xs[i-1]];
      for (int kk = 1; kk <= int'(MAXS); kk++) begin
         if (kk % 2 == 0 && xs[kk/2] == xs[kk]) begin
            k = kk;
            break;
         end
      end
      if (k == 0) begin
         e.tmo      = 1;
         e.busy_cyc = 2 + 2 * MAXS;
         return e;
      end
      e.meet = k;
      e.snap = xs[k/2];
      for (int p = 1; p <= int'(MAXS); p++) begin
         if (xs[k+p] == xs[k/2]) begin
            e.done     = 1;
            e.period   = p;
            e.busy_cyc = 2 + 2 * k + 2 * p;
            break;
         end
         if (p == int'(MAXS)) begin
            e.tmo      = 1;
            e.busy_cyc = 2 + 2 * k + 2 * p;
         end
      end
      return e;
   endfunction

   // Monitor: a run ends when busy falls; pop and compare.
   initial begin : monitor
      bit          prev_busy;
      int unsigned busy_cnt;
      exp_t        e;
      prev_busy = 0;
      busy_cnt  = 0;
      forever begin
         @(negedge clk);
         if ((bus.start_s0 || bus.start_s1 || bus.reset_nos) && !bus.busy) idle_strobes++;
         if (bus.reset_nos && (bus.start_s0 || bus.start_s1)) overlap++;
         if (bus.busy) busy_cnt++;
         if (prev_busy && !bus.busy) begin
            if (exp_q.size() == 0) begin
               check("unexpected_result", 64'(busy_cnt), 64'd0);
            end else begin
               e = exp_q.pop_front();
               if (e.aborted) begin
                  check("abort_done", bus.done, 0);
                  check("abort_timeout", bus.timeout, 0);
                  check("abort_meet", bus.meet_steps, 0);
                  check("abort_period", bus.period, 0);
                  check("abort_init_state", bus.init_state, 0);
                  check("abort_strobes", {bus.reset_nos, bus.start_s0, bus.start_s1}, 0);
`ifdef ATTRACTOR_SNAP_EN
                  check("abort_snap", bus.snap_vec, 0);
`endif
               end else begin
                  check("done", bus.done, 64'(e.done));
                  check("timeout", bus.timeout, 64'(e.tmo));
                  check("busy_cycles", 64'(busy_cnt), 64'(e.busy_cyc));
                  if (e.done) begin
                     check("meet_steps", bus.meet_steps, 64'(e.meet));
                     check("period", bus.period, 64'(e.period));
`ifdef ATTRACTOR_SNAP_EN
                     check("snap_vec", bus.snap_vec, 64'(e.snap));
`endif
                  end
               end
            end
            busy_cnt = 0;
         end
         prev_busy = bus.busy;
      end
   end

   task automatic wait_idle(input string name);
      int unsigned n;
      n = 0;
      while (bus.busy && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (bus.busy) begin
         checks++;
         errors++;
         $display("FAIL %s: busy still %0d after %0d cycles, required 0", name, bus.busy, n);
      end
   endtask

   // poke: pulse go (with a different init) during the first CHECK.
   // abort: assert rst during the first PSTEP.
   task automatic do_run(input logic [3:0] init, input bit poke, input bit abort);
      exp_t e;
      bit   seen;
      e = model(init);
      if (abort) e.aborted = 1;
      exp_q.push_back(e);
      bus.init_vec = init;
      bus.go       = 1'b1;
      @(negedge clk);
      bus.go       = 1'b0;
      bus.init_vec = 4'($urandom);
      if (poke) begin
         seen = 0;
         for (int i = 0; i < 50 && !seen; i++) begin
            if (bus.start_s0) seen = 1;
            else @(negedge clk);
         end
         check("poke_step_seen", 64'(seen), 64'd1);
         @(negedge clk);
         bus.go       = 1'b1;
         bus.init_vec = ~init;
         @(negedge clk);
         bus.go       = 1'b0;
      end
      if (abort) begin
         seen = 0;
         for (int i = 0; i < 100 && !seen; i++) begin
            if (bus.start_s1 && !bus.start_s0) seen = 1;
            else @(negedge clk);
         end
         check("abort_pstep_seen", 64'(seen), 64'd1);
         rst = 1'b1;
         @(negedge clk);
         rst = 1'b0;
      end
      wait_idle("run_finish");
      repeat (3) @(negedge clk);
   endtask

   task automatic set_mod6();
      for (int i = 0; i < 16; i++) f_tab[i] = (i < 6) ? 4'((i + 1) % 6) : 4'd0;
   endtask

   initial begin
      bus.go       = 1'b0;
      bus.init_vec = '0;
      for (int i = 0; i < 16; i++) f_tab[i] = 4'(i);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_timeout", bus.timeout, 0);
      check("rst_reset_nos", bus.reset_nos, 0);
      check("rst_start_s0", bus.start_s0, 0);
      check("rst_start_s1", bus.start_s1, 0);
      check("rst_meet", bus.meet_steps, 0);
      check("rst_period", bus.period, 0);
      check("rst_init_state", bus.init_state, 0);
      rst = 1'b0;
      @(negedge clk);

      // x -> (x+1) mod 6
      set_mod6();
      do_run(4'd0, 0, 0);

      // Transient 0..2, cycle 3..6; go poked during CHECK
      for (int i = 0; i < 16; i++) f_tab[i] = (i < 6) ? 4'(i + 1) : (i == 6) ? 4'd3 : 4'd0;
      do_run(4'd0, 1, 0);

      // Fixed point everywhere
      for (int i = 0; i < 16; i++) f_tab[i] = 4'(i);
      do_run(4'd9, 0, 0);

      // 16-state cycle: no meet within MAXS hare steps
      for (int i = 0; i < 16; i++) f_tab[i] = 4'((i + 1) % 16);
      do_run(4'd0, 0, 0);
      repeat (10) @(negedge clk);

      // Abort in PSTEP, then identical rerun
      set_mod6();
      do_run(4'd0, 0, 1);
      do_run(4'd0, 0, 0);

      // Random networks
      repeat (24) begin
         for (int i = 0; i < 16; i++) f_tab[i] = 4'($urandom_range(0, 15));
         do_run(4'($urandom_range(0, 15)), 0, 0);
      end

      repeat (5) @(negedge clk);
      check("queue_drained", 64'(exp_q.size()), 64'd0);
      check("idle_strobes", 64'(idle_strobes), 64'd0);
      check("strobe_overlap", 64'(overlap), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
